// File: rtl/bus_reorder_pipe.sv
// Small FIFO that applies a per-beat bit transform (pass, reverse,
// half-swap, tie) at acceptance and returns words in strict order.
// Ports:
//   clk, rst            - clock, async active-high reset
//   flush               - synchronous clear of all buffered words
//   mode[1:0]           - 00 pass, 01 bit-reverse, 10 half-swap, 11 tie
//   in_valid/in_ready   - upstream handshake, in_data[WIDTH-1:0]
//   out_valid/out_ready - downstream handshake, out_data[WIDTH-1:0]
//   level               - current occupancy
module bus_reorder_pipe #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int TIE_VALUE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic          TIE_BIT  = (TIE_VALUE != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [1:0]       st_q, st_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [WIDTH-1:0] rev_word;
  logic [WIDTH-1:0] swap_word;
  logic [WIDTH-1:0] xf_word;
  logic             acc;
  logic             cons;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshakes come straight from the state register, so
  // out_ready never reaches in_ready combinationally.
  assign in_ready  = (st_q != ST_FULL);
  assign out_valid = (st_q != ST_EMPTY);
  assign out_data  = dout_q;
  assign level     = lvl_q;

  assign acc  = in_valid & in_ready & ~flush;
  assign cons = out_valid & out_ready & ~flush;

  for (genvar k = 0; k < WIDTH; k++) begin : g_rev
    assign rev_word[k] = in_data[WIDTH-1-k];
  end

  assign swap_word = {in_data[WIDTH/2-1:0],
                      in_data[WIDTH-1:WIDTH/2]};

  always_comb begin
    xf_word = in_data;
    unique case (1'b1)
      (mode == 2'b00): xf_word = in_data;
      (mode == 2'b01): xf_word = rev_word;
      (mode == 2'b10): xf_word = swap_word;
      (mode == 2'b11): xf_word = {WIDTH{TIE_BIT}};
      default:         xf_word = in_data;
    endcase
  end

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    lvl_d  = lvl_q;
    dout_d = dout_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      lvl_d = '0;
    end else begin
      if (acc)  wr_d = nxt(wr_q);
      if (cons) rd_d = nxt(rd_q);
      lvl_d = lvl_q + LW'(acc) - LW'(cons);
      // The new head is the word written this edge only when
      // it lands on the slot the read pointer moves to.
      if (lvl_d != '0) begin
        if (acc && (wr_q == rd_d)) dout_d = xf_word;
        else                       dout_d = mem_q[rd_d];
      end
    end
  end

  always_comb begin
    st_d = ST_PART;
    unique case (1'b1)
      (lvl_d == '0):      st_d = ST_EMPTY;
      (lvl_d == LVL_FULL): st_d = ST_FULL;
      default:            st_d = ST_PART;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      lvl_q  <= '0;
      st_q   <= ST_EMPTY;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      lvl_q  <= lvl_d;
      st_q   <= st_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= xf_word;
  end

endmodule

// File: tb/tb_bus_reorder_pipe.sv
// Directed + random scoreboard bench for bus_reorder_pipe.
// Two instances: W4/D2/tie0 and W8/D3/tie1.
module tb_bus_reorder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_fl, a_vi, a_ro, a_ir, a_ov;
  logic [1:0] a_mode, a_lvl;
  logic [3:0] a_di, a_do;

  logic       b_fl, b_vi, b_ro, b_ir, b_ov;
  logic [1:0] b_mode, b_lvl;
  logic [7:0] b_di, b_do;

  bus_reorder_pipe #(.WIDTH(4), .DEPTH(2), .TIE_VALUE(0)) u_a (
    .clk(clk), .rst(rst), .flush(a_fl), .mode(a_mode),
    .in_valid(a_vi), .in_ready(a_ir), .in_data(a_di),
    .out_valid(a_ov), .out_ready(a_ro), .out_data(a_do),
    .level(a_lvl)
  );

  bus_reorder_pipe #(.WIDTH(8), .DEPTH(3), .TIE_VALUE(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_fl), .mode(b_mode),
    .in_valid(b_vi), .in_ready(b_ir), .in_data(b_di),
    .out_valid(b_ov), .out_ready(b_ro), .out_data(b_do),
    .level(b_lvl)
  );

  int ncomp = 0;
  int nfail = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         lvl[2];
  logic [7:0] last[2];
  int         popped[2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xf(input int w, input logic [7:0] d,
                                    input logic [1:0] m, input logic t);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < w; k++) begin
      case (m)
        2'd0: r[k] = d[k];
        2'd1: r[k] = d[w-1-k];
        2'd2: r[k] = (k < w/2) ? d[k+w/2] : d[k-w/2];
        default: r[k] = t;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    lvl[0] = 0; lvl[1] = 0;
    last[0] = '0; last[1] = '0;
  endtask

  // One clock cycle on unit u; called at posedge+1.
  task automatic cyc(input int u, input logic v, input logic [7:0] d,
                     input logic [1:0] m, input logic r, input logic f);
    int dep, w, lv;
    logic t, acc, cons, o_rdy, o_vld;
    logic [7:0] o_dat, head;
    logic [1:0] o_lvl;
    dep = (u == 0) ? 2 : 3;
    w   = (u == 0) ? 4 : 8;
    t   = (u == 0) ? 1'b0 : 1'b1;
    if (u == 0) begin
      a_vi = v; a_di = d[3:0]; a_mode = m; a_ro = r; a_fl = f;
      o_rdy = a_ir; o_vld = a_ov; o_dat = {4'h0, a_do};
      head = (qa.size() != 0) ? qa[0] : 8'h0;
    end else begin
      b_vi = v; b_di = d; b_mode = m; b_ro = r; b_fl = f;
      o_rdy = b_ir; o_vld = b_ov; o_dat = b_do;
      head = (qb.size() != 0) ? qb[0] : 8'h0;
    end
    lv = lvl[u];
    chk($sformatf("u%0d in_ready", u), o_rdy, lv < dep);
    chk($sformatf("u%0d out_valid", u), o_vld, lv != 0);
    if (lv != 0) chk($sformatf("u%0d out_data", u), o_dat, head);
    else chk($sformatf("u%0d out_hold", u), o_dat, last[u]);
    acc  = v && (lv < dep) && !f;
    cons = (lv != 0) && r && !f;
    if (f) begin
      if (u == 0) qa.delete(); else qb.delete();
      lvl[u] = 0;
    end else begin
      if (cons) begin
        if (u == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        popped[u]++;
      end
      if (acc) begin
        if (u == 0) qa.push_back(xf(w, d, m, t));
        else qb.push_back(xf(w, d, m, t));
      end
      lvl[u] = lv + int'(acc) - int'(cons);
    end
    if (u == 0 && qa.size() != 0) last[0] = qa[0];
    if (u == 1 && qb.size() != 0) last[1] = qb[0];
    @(posedge clk);
    #1;
    o_lvl = (u == 0) ? a_lvl : b_lvl;
    chk($sformatf("u%0d level", u), o_lvl, lvl[u]);
    if (u == 0) begin a_vi = 1'b0; a_fl = 1'b0; end
    else begin b_vi = 1'b0; b_fl = 1'b0; end
  endtask

  initial begin
    int pushed;
    a_fl = 0; a_vi = 0; a_ro = 0; a_mode = 0; a_di = 0;
    b_fl = 0; b_vi = 0; b_ro = 0; b_mode = 0; b_di = 0;
    popped[0] = 0; popped[1] = 0;
    model_reset();
    rst = 1'b1;
    #3;
    chk("rst a_level", a_lvl, 0);
    chk("rst a_in_ready", a_ir, 1);
    chk("rst a_out_valid", a_ov, 0);
    chk("rst a_out_data", a_do, 0);
    chk("rst b_out_data", b_do, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // bit-reverse 0001 -> 1000, one-cycle latency
    cyc(0, 1, 8'h1, 2'b01, 1, 0);
    chk("s042 out_data", a_do, 4'b1000);
    chk("s042 out_valid", a_ov, 1);
    cyc(0, 0, 8'h0, 2'b01, 1, 0);
    chk("s042 drained", a_lvl, 0);

    // fill, stall, then drain in order
    cyc(0, 1, 8'hA, 2'b00, 0, 0);
    cyc(0, 1, 8'h5, 2'b00, 0, 0);
    cyc(0, 1, 8'h3, 2'b00, 0, 0);
    chk("s043 full level", a_lvl, 2);
    chk("s043 stall ready", a_ir, 0);
    cyc(0, 1, 8'h3, 2'b00, 1, 0);
    cyc(0, 1, 8'h3, 2'b00, 1, 0);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    chk("s043 popped", popped[0], 4);

    // transform fixed at acceptance; later mode change ignored
    cyc(0, 1, 8'h3, 2'b10, 0, 0);
    cyc(0, 1, 8'h5, 2'b11, 0, 0);
    cyc(0, 0, 8'h0, 2'b01, 1, 0);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);

    // flush with coincident accept and consume
    cyc(0, 1, 8'h9, 2'b00, 0, 0);
    cyc(0, 1, 8'h6, 2'b01, 0, 0);
    cyc(0, 1, 8'hE, 2'b00, 1, 1);
    chk("s046 level", a_lvl, 0);
    chk("s046 out_valid", a_ov, 0);
    chk("s046 hold", a_do, 4'h9);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    cyc(0, 1, 8'h2, 2'b00, 1, 0);
    chk("s046 new head", a_do, 4'h2);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);

    // half-swap then tie on the 8-bit instance
    cyc(1, 1, 8'h12, 2'b10, 0, 0);
    cyc(1, 1, 8'h00, 2'b11, 0, 0);
    chk("s044 first", b_do, 8'h21);
    cyc(1, 0, 8'h00, 2'b00, 1, 0);
    chk("s044 second", b_do, 8'hFF);
    cyc(1, 0, 8'h00, 2'b00, 1, 0);

    // random push/pop with stalls on the depth-3 instance
    pushed = 0;
    popped[1] = 0;
    for (int i = 0; i < 80 && pushed < 10; i++) begin
      logic v, r;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 3) != 0);
      if (v && lvl[1] < 3) pushed++;
      cyc(1, v, 8'($urandom), 2'($urandom_range(0, 3)), r, 0);
    end
    for (int i = 0; i < 12 && lvl[1] != 0; i++)
      cyc(1, 0, 8'h0, 2'b00, 1, 0);
    chk("s045 pushed", pushed, 10);
    chk("s045 popped", popped[1], 10);

    // async reset between edges with one word buffered
    cyc(0, 1, 8'h7, 2'b00, 0, 0);
    cyc(1, 1, 8'h5A, 2'b00, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("s047 out_valid", a_ov, 0);
    chk("s047 out_data", a_do, 0);
    chk("s047 in_ready", a_ir, 1);
    chk("s047 level", a_lvl, 0);
    chk("s047 b_out_data", b_do, 0);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    cyc(0, 1, 8'hB, 2'b00, 1, 0);
    cyc(0, 0, 8'h0, 2'b00, 1, 0);
    cyc(1, 0, 8'h0, 2'b00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/bus_reorder_pipe.md
BUS_REORDER_PIPE -- requirements
Module: bus_reorder_pipe

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data bus width in bits (legal range 2..64, even).
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffer entries (legal range 1..16).
REQ-003 Parameter TIE_VALUE, default 0, SHALL set the bit value driven on every data bit in tie mode (0 or 1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 flush  input  1  SHALL be the synchronous buffer clear.
REQ-007 mode  input  2  SHALL select the transform: 00 pass, 01 bit-reverse, 10 half-swap, 11 tie.
REQ-008 in_valid  input  1  SHALL mark in_data as offered.
REQ-009 in_ready  output  1  SHALL mark the block as able to accept.
REQ-010 in_data  input  WIDTH  SHALL be the descending-range input word [WIDTH-1:0].
REQ-011 out_valid  output  1  SHALL mark out_data as valid.
REQ-012 out_ready  input  1  SHALL mark the downstream as able to accept.
REQ-013 out_data  output  WIDTH  SHALL be the transformed word, oldest buffered entry.
REQ-014 level  output  $clog2(DEPTH+1)  SHALL be the current occupancy.

Function
REQ-015 An input beat SHALL be accepted on a clock edge where in_valid && in_ready && !flush.
REQ-016 An output beat SHALL be consumed on a clock edge where out_valid && out_ready && !flush.
REQ-017 The transform SHALL be applied at acceptance, using the mode value sampled on that edge; a later mode change SHALL NOT alter buffered entries.
REQ-018 Pass mode SHALL store out[k] = in[k].
REQ-019 Bit-reverse mode SHALL store out[k] = in[WIDTH-1-k].
REQ-020 Half-swap mode SHALL store {in[WIDTH/2-1:0], in[WIDTH-1:WIDTH/2]}.
REQ-021 Tie mode SHALL store all bits equal to TIE_VALUE, regardless of in_data.
REQ-022 in_ready SHALL equal (level < DEPTH) and SHALL be purely registered-state derived, with no combinational path from out_ready.
REQ-023 out_valid SHALL equal (level != 0).
REQ-024 out_data SHALL present the entry at the read pointer whenever out_valid is 1.
REQ-025 out_data SHALL hold its last value while out_valid is 0.
REQ-026 Latency SHALL be one cycle: a word accepted on edge N SHALL be visible with out_valid=1 after edge N when the buffer was empty. There is no same-cycle bypass.
REQ-027 Order SHALL be strict FIFO.
REQ-028 On an edge with simultaneous accept and consume, level SHALL be unchanged and both pointers SHALL advance.
REQ-029 When full, in_ready SHALL be 0, and in_valid SHALL NOT be accepted even if out_ready=1 on that cycle.
REQ-030 When empty, out_ready SHALL have no effect.
REQ-031 Read and write pointers SHALL wrap from DEPTH-1 to 0, including for DEPTH values that are not a power of two.
REQ-032 When flush=1, the block SHALL set level, read pointer and write pointer to 0 on that edge.
REQ-033 When flush=1, any coincident accept or consume SHALL be discarded.
REQ-034 When flush=1, out_data SHALL hold its last value.
REQ-035 The internal state SHALL be EMPTY (level=0), PARTIAL (0<level<DEPTH) or FULL (level=DEPTH).
REQ-036 State transitions SHALL follow only from accept, consume and flush per REQ-015 to REQ-033.
REQ-037 For DEPTH=1, the block SHALL alternate strictly between EMPTY and FULL.

Reset
REQ-038 Asserting rst SHALL immediately, without a clock edge, force level=0, pointers=0, out_valid=0, in_ready=1 and out_data=0.
REQ-039 Buffer storage contents SHALL NOT need to be reset.
REQ-040 Reset asserted mid-transfer SHALL discard all buffered words; no beat SHALL be reported after release until a new accept occurs.
REQ-041 On the first clock edge after rst deasserts, the block SHALL be able to accept a beat.

Verification
REQ-042 Scenario: WIDTH=4, mode=01, in_data=4'b0001 accepted, out_ready=1 -> next cycle out_valid=1, out_data=4'b1000, then level returns to 0.
REQ-043 Scenario: DEPTH=2, mode=00, push 4'hA, 4'h5, 4'h3 with out_ready=0 -> third beat stalls (in_ready=0, level=2); release out_ready -> outputs A, 5, 3 in order.
REQ-044 Scenario: WIDTH=8, mode=10, push 8'h12 then switch mode to 11 with TIE_VALUE=1 and push 8'h00 -> outputs 8'h21 then 8'hFF.
REQ-045 Scenario: DEPTH=3, continuous push and pop for 10 beats with random stalls -> no loss, no duplication, pointer wrap exercised, level never exceeds 3.
REQ-046 Scenario: level=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, and the flushed-cycle input does not appear later.
REQ-047 Scenario: level=1, assert rst asynchronously between clock edges -> out_valid=0 and out_data=0 before the next edge, and in_ready=1.
